// File: rtl/mem_bus_sched_pkg.sv
// Shared encodings and parameter defaults for the shared memory-port scheduler.
package mem_bus_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_MEM,
        OWN_WB
    } owner_t;

    localparam int STARVE_MAX_DEF = 4;
    localparam int TIMEOUT_DEF    = 64;

endpackage

// File: rtl/mem_bus_sched_if.sv
// Memory-side bus of the scheduler: registered request outputs, ready/rvalid/rdata back.
interface mem_bus_sched_if;

    logic        bus_cs_en_ctl;
    logic        bus_wen_ctl;
    logic [31:0] bus_addr_ctl;
    logic [31:0] bus_wdata_ctl;
    logic        bus_ready_top;
    logic        bus_rvalid_top;
    logic [31:0] bus_rdata_top;

    modport master (
        output bus_cs_en_ctl, bus_wen_ctl, bus_addr_ctl, bus_wdata_ctl,
        input  bus_ready_top, bus_rvalid_top, bus_rdata_top
    );

    modport slave (
        input  bus_cs_en_ctl, bus_wen_ctl, bus_addr_ctl, bus_wdata_ctl,
        output bus_ready_top, bus_rvalid_top, bus_rdata_top
    );

endinterface

// File: rtl/mem_bus_pick.sv
// Combinational priority picker: WB > MEM > IF, except a starved IF wins outright.
module mem_bus_pick
    import mem_bus_sched_pkg::*;
(
    input  logic   if_req,
    input  logic   mem_req,
    input  logic   wb_req,
    input  logic   if_starved,
    output owner_t winner
);

    always_comb begin
        // NOTE: default assignment first so no path leaves winner unassigned (no latch).
        winner = OWN_NONE;
        if (if_starved && if_req) begin
            winner = OWN_IF;
        end else if (wb_req) begin
            winner = OWN_WB;
        end else if (mem_req) begin
            winner = OWN_MEM;
        end else if (if_req) begin
            winner = OWN_IF;
        end
    end

endmodule

// File: rtl/mem_bus_sched.sv
// Request/grant/response sequencer for the single shared instruction/data memory port.
module mem_bus_sched
    import mem_bus_sched_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_b,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        mem_req,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,

    input  logic        wb_req,
    input  logic [31:0] wb_addr,
    input  logic [31:0] wb_wdata,
    output logic        wb_gnt,

    mem_bus_sched_if.master bus,

    output logic        busy_ctl,
    output logic        bus_err_ctl
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TMO_LIM    = 8'(TIMEOUT);

    state_t     state;
    owner_t     owner;
    owner_t     winner;
    logic [3:0] starve_cnt;
    logic [7:0] tmo_cnt;
    logic       drop;

    mem_bus_pick u_pick (
        .if_req     (if_req),
        .mem_req    (mem_req),
        .wb_req     (wb_req),
        .if_starved (starve_cnt == STARVE_LIM),
        .winner     (winner)
    );

    // Completion events; gnt and rvalid follow the memory handshake in the same cycle.
    logic ready_hit;
    logic rsp_ok;
    logic rsp_tmo;
    logic rsp;
    logic if_discard;

    assign ready_hit  = (state == ST_ADDR) && bus.bus_ready_top;
    assign rsp_ok     = (state == ST_DATA) && bus.bus_rvalid_top;
    assign rsp_tmo    = (state == ST_DATA) && !bus.bus_rvalid_top && (tmo_cnt == TMO_LIM);
    assign rsp        = rsp_ok || rsp_tmo;
    assign if_discard = (owner == OWN_IF) && (drop || if_flush);

    assign if_gnt     = ready_hit && (owner == OWN_IF);
    assign mem_gnt    = ready_hit && (owner == OWN_MEM);
    assign wb_gnt     = ready_hit && (owner == OWN_WB);

    assign if_rvalid  = rsp && (owner == OWN_IF) && !if_discard;
    assign mem_rvalid = rsp && (owner == OWN_MEM);
    assign if_rdata   = (if_rvalid && rsp_ok)  ? bus.bus_rdata_top : 32'h0;
    assign mem_rdata  = (mem_rvalid && rsp_ok) ? bus.bus_rdata_top : 32'h0;

    assign bus_err_ctl = rsp_tmo && !if_discard;
    assign busy_ctl    = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state             <= ST_IDLE;
            owner             <= OWN_NONE;
            starve_cnt        <= 4'd0;
            tmo_cnt           <= 8'd0;
            drop              <= 1'b0;
            bus.bus_cs_en_ctl <= 1'b0;
            bus.bus_wen_ctl   <= 1'b0;
            bus.bus_addr_ctl  <= 32'h0;
            bus.bus_wdata_ctl <= 32'h0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
            unique case (state)
                ST_IDLE: begin
                    drop <= 1'b0;
                    if (if_req) begin
                        if (winner == OWN_IF) begin
                            starve_cnt <= 4'd0;
                        end else if (starve_cnt != 4'hF) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                    if (winner != OWN_NONE) begin
                        owner             <= winner;
                        state             <= ST_ADDR;
                        bus.bus_cs_en_ctl <= 1'b1;
                        unique case (winner)
                            OWN_WB: begin
                                bus.bus_wen_ctl   <= 1'b1;
                                bus.bus_addr_ctl  <= wb_addr;
                                bus.bus_wdata_ctl <= wb_wdata;
                            end
                            OWN_MEM: begin
                                bus.bus_wen_ctl   <= mem_wen;
                                bus.bus_addr_ctl  <= mem_addr;
                                bus.bus_wdata_ctl <= mem_wdata;
                            end
                            default: begin
                                bus.bus_wen_ctl   <= 1'b0;
                                bus.bus_addr_ctl  <= if_addr;
                                bus.bus_wdata_ctl <= 32'h0;
                            end
                        endcase
                    end else begin
                        bus.bus_cs_en_ctl <= 1'b0;
                    end
                end

                ST_ADDR: begin
                    if (if_flush && owner == OWN_IF) drop <= 1'b1;
                    if (bus.bus_ready_top) begin
                        bus.bus_cs_en_ctl <= 1'b0;
                        if (bus.bus_wen_ctl) begin
                            state <= ST_IDLE;
                            owner <= OWN_NONE;
                        end else begin
                            state   <= ST_DATA;
                            tmo_cnt <= 8'd0;
                        end
                    end
                end

                ST_DATA: begin
                    if (if_flush && owner == OWN_IF) drop <= 1'b1;
                    if (rsp) begin
                        state <= ST_IDLE;
                        owner <= OWN_NONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    owner <= OWN_NONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_sched.sv
// Directed bench for mem_bus_sched with a small wait-state memory responder.
`timescale 1ns/1ps
module tb_mem_bus_sched;
    import mem_bus_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b;
    logic        if_req, if_flush, mem_req, mem_wen, wb_req;
    logic [31:0] if_addr, mem_addr, mem_wdata, wb_addr, wb_wdata;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, wb_gnt, busy_ctl, bus_err_ctl;
    logic [31:0] if_rdata, mem_rdata;

    mem_bus_sched_if bus ();

    mem_bus_sched #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_flush    (if_flush),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .mem_req     (mem_req),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .wb_req      (wb_req),
        .wb_addr     (wb_addr),
        .wb_wdata    (wb_wdata),
        .wb_gnt      (wb_gnt),
        .bus         (bus),
        .busy_ctl    (busy_ctl),
        .bus_err_ctl (bus_err_ctl)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory responder configuration and state
    int          cfg_ready_wait  = 0;
    int          cfg_rvalid_wait = 1;
    logic [31:0] cfg_rdata       = 32'h0;
    bit          cfg_never       = 1'b0;
    int          a_cnt = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    bit          mem_reissue = 1'b0;

    // Per-test logs
    int          cyc = 0;
    int          n_if_gnt, n_mem_gnt, n_wb_gnt, n_if_rv, n_mem_rv, n_err, n_err_rv, n_bus_rv, n_busy_low;
    int          mem_gnt_cyc, mem_rv_cyc;
    int          viol = 0;
    logic [31:0] last_if_rdata, last_mem_rdata;
    owner_t      gq[$];
    logic        wq[$];

    task automatic clear_logs();
        n_if_gnt = 0; n_mem_gnt = 0; n_wb_gnt = 0; n_if_rv = 0; n_mem_rv = 0;
        n_err = 0; n_err_rv = 0; n_bus_rv = 0; n_busy_low = 0;
        mem_gnt_cyc = -1; mem_rv_cyc = -1;
        last_if_rdata = 32'hFFFF_FFFF; last_mem_rdata = 32'hFFFF_FFFF;
        gq.delete(); wq.delete();
    endtask

    // One clock: drive memory inputs at the falling edge, sample 1ns later.
    task automatic tick();
        @(negedge clk);
        bus.bus_rvalid_top = 1'b0;
        bus.bus_rdata_top  = 32'h0;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                pend = 1'b0;
                bus.bus_rvalid_top = 1'b1;
                bus.bus_rdata_top  = cfg_rdata;
            end
        end
        bus.bus_ready_top = 1'b0;
        if (bus.bus_cs_en_ctl) begin
            if (a_cnt == cfg_ready_wait) begin
                bus.bus_ready_top = 1'b1;
                if (!bus.bus_wen_ctl && !cfg_never) begin
                    pend = 1'b1;
                    pend_cnt = cfg_rvalid_wait;
                end
            end
            a_cnt++;
        end else begin
            a_cnt = 0;
        end
        #1;
        cyc++;
        if (if_gnt)  begin n_if_gnt++;  gq.push_back(OWN_IF);  wq.push_back(bus.bus_wen_ctl); if_req = 1'b0; end
        if (mem_gnt) begin n_mem_gnt++; gq.push_back(OWN_MEM); wq.push_back(bus.bus_wen_ctl); mem_gnt_cyc = cyc;
                           if (!mem_reissue) mem_req = 1'b0; end
        if (wb_gnt)  begin n_wb_gnt++;  gq.push_back(OWN_WB);  wq.push_back(bus.bus_wen_ctl); wb_req = 1'b0; end
        if (if_rvalid)  begin n_if_rv++;  last_if_rdata = if_rdata; end
        if (mem_rvalid) begin n_mem_rv++; last_mem_rdata = mem_rdata; mem_rv_cyc = cyc; end
        if (bus_err_ctl) n_err++;
        if (bus_err_ctl && mem_rvalid) n_err_rv++;
        if (bus.bus_rvalid_top) n_bus_rv++;
        if (!busy_ctl) n_busy_low++;
        if (!if_rvalid && if_rdata != 32'h0) viol++;
        if (!mem_rvalid && mem_rdata != 32'h0) viol++;
        if ($countones({if_gnt, mem_gnt, wb_gnt, if_rvalid, mem_rvalid}) > 1) viol++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while ((busy_ctl || pend) && k < budget) begin
            tick();
            k++;
        end
        if (busy_ctl || pend) check({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic logic [31:0] any_out();
        return 32'({if_gnt, if_rvalid, |if_rdata, mem_gnt, mem_rvalid, |mem_rdata, wb_gnt,
                    bus.bus_cs_en_ctl, bus.bus_wen_ctl, |bus.bus_addr_ctl, |bus.bus_wdata_ctl,
                    busy_ctl, bus_err_ctl} != 13'd0);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int start, k, rel;
        rst_b = 1'b0;
        if_req = 0; if_flush = 0; mem_req = 0; mem_wen = 0; wb_req = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0; wb_addr = 0; wb_wdata = 0;
        bus.bus_ready_top = 0; bus.bus_rvalid_top = 0; bus.bus_rdata_top = 0;
        clear_logs();

        // Reset state
        #12;
        check("reset_outputs", any_out(), 32'd0);
        check("reset_starve", 32'(dut.starve_cnt), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        #1;

        // Zero-wait write latency: cs and gnt at t+1, back in IDLE at t+2
        clear_logs();
        wb_addr = 32'h10; wb_wdata = 32'hA5A5_0001; wb_req = 1'b1;
        tick();
        check("wr_cs_t1", 32'(bus.bus_cs_en_ctl), 32'd1);
        check("wr_gnt_t1", 32'(n_wb_gnt), 32'd1);
        check("wr_bus_wen", 32'(bus.bus_wen_ctl), 32'd1);
        check("wr_bus_addr", bus.bus_addr_ctl, 32'h10);
        check("wr_bus_wdata", bus.bus_wdata_ctl, 32'hA5A5_0001);
        tick();
        check("wr_cs_t2", 32'(bus.bus_cs_en_ctl), 32'd0);
        check("wr_busy_t2", 32'(busy_ctl), 32'd0);

        // Zero-wait read latency: gnt at t+1, data at t+2
        clear_logs();
        cfg_ready_wait = 0; cfg_rvalid_wait = 1; cfg_rdata = 32'h0BAD_F00D;
        mem_wen = 1'b0; mem_addr = 32'h20; mem_req = 1'b1;
        tick();
        check("rd_gnt_t1", 32'(mem_gnt), 32'd1);
        tick();
        check("rd_rvalid_t2", 32'(mem_rvalid), 32'd1);
        check("rd_rdata_t2", mem_rdata, 32'h0BAD_F00D);
        tick();
        check("rd_busy_t3", 32'(busy_ctl), 32'd0);

        // Priority: WB, then MEM, then IF
        clear_logs();
        cfg_rdata = 32'h0000_0011;
        wb_addr = 32'h200; wb_wdata = 32'h1234; wb_req = 1'b1;
        mem_addr = 32'h100; mem_wen = 1'b0; mem_req = 1'b1;
        if_addr = 32'h40; if_req = 1'b1;
        k = 0;
        while (!(gq.size() == 3 && n_if_rv == 1) && k < 40) begin tick(); k++; end
        check("prio_count", 32'(gq.size()), 32'd3);
        check("prio_first", 32'(gq[0]), 32'(OWN_WB));
        check("prio_second", 32'(gq[1]), 32'(OWN_MEM));
        check("prio_third", 32'(gq[2]), 32'(OWN_IF));
        check("prio_wen", {29'd0, wq[0], wq[1], wq[2]}, 32'b100);
        check("prio_mem_rdata", last_mem_rdata, 32'h11);
        check("prio_if_rdata", last_if_rdata, 32'h11);
        wait_idle("prio", 20);

        // Wait states: ready after 3 low cycles, rvalid 2 cycles after ready
        clear_logs();
        cfg_ready_wait = 3; cfg_rvalid_wait = 2; cfg_rdata = 32'hDEAD_BEEF;
        mem_addr = 32'h100; mem_wen = 1'b0; mem_req = 1'b1;
        start = cyc;
        run(6);
        check("ws_gnt_count", 32'(n_mem_gnt), 32'd1);
        check("ws_gnt_cycle", 32'(mem_gnt_cyc - start), 32'd4);
        check("ws_rv_count", 32'(n_mem_rv), 32'd1);
        check("ws_rv_cycle", 32'(mem_rv_cyc - start), 32'd6);
        check("ws_rdata", last_mem_rdata, 32'hDEAD_BEEF);
        check("ws_busy", 32'(n_busy_low), 32'd0);
        wait_idle("ws", 20);

        // Starvation: MEM writes re-issued every arbitration, IF wins the 5th
        clear_logs();
        cfg_ready_wait = 0; cfg_rvalid_wait = 1; cfg_rdata = 32'h0000_0077;
        mem_reissue = 1'b1; mem_wen = 1'b1; mem_addr = 32'h300; mem_wdata = 32'h5;
        mem_req = 1'b1; if_addr = 32'h60; if_req = 1'b1;
        k = 0;
        while (n_if_gnt == 0 && k < 40) begin tick(); k++; end
        mem_reissue = 1'b0; mem_req = 1'b0;
        check("starve_arbs", 32'(gq.size()), 32'd5);
        check("starve_4th_mem", 32'(gq[3]), 32'(OWN_MEM));
        check("starve_5th_if", 32'(gq[4]), 32'(OWN_IF));
        check("starve_cleared", 32'(dut.starve_cnt), 32'd0);
        wait_idle("starve", 20);
        check("starve_if_data", last_if_rdata, 32'h77);

        // Flush during IF DATA: response consumed on the bus but not delivered
        clear_logs();
        mem_wen = 1'b0;
        cfg_ready_wait = 0; cfg_rvalid_wait = 3; cfg_rdata = 32'h13;
        if_addr = 32'h80; if_req = 1'b1;
        tick();
        tick();
        if_flush = 1'b1;
        tick();
        if_flush = 1'b0;
        run(4);
        check("flush_gnt", 32'(n_if_gnt), 32'd1);
        check("flush_bus_rv", 32'(n_bus_rv), 32'd1);
        check("flush_no_rvalid", 32'(n_if_rv), 32'd0);
        check("flush_idle", 32'(busy_ctl), 32'd0);
        clear_logs();
        cfg_rvalid_wait = 1; cfg_rdata = 32'h22;
        if_addr = 32'h84; if_req = 1'b1;
        run(3);
        check("post_flush_rv", 32'(n_if_rv), 32'd1);
        check("post_flush_data", last_if_rdata, 32'h22);

        // Timeout: rvalid never arrives
        clear_logs();
        cfg_never = 1'b1;
        mem_addr = 32'h300; mem_wen = 1'b0; mem_req = 1'b1;
        k = 0;
        while (n_mem_rv == 0 && k < 90) begin tick(); k++; end
        rel = mem_rv_cyc - mem_gnt_cyc;
        check("tmo_not_early", 32'(rel >= 64), 32'd1);
        check("tmo_not_late", 32'(rel <= 65 && n_mem_rv == 1), 32'd1);
        check("tmo_rdata", last_mem_rdata, 32'h0);
        check("tmo_err_with_rv", 32'(n_err_rv), 32'd1);
        check("tmo_err_count", 32'(n_err), 32'd1);
        tick();
        check("tmo_idle", 32'(busy_ctl), 32'd0);
        cfg_never = 1'b0;

        // Reset while in DATA, then normal operation
        clear_logs();
        cfg_rvalid_wait = 20; cfg_rdata = 32'h99;
        mem_addr = 32'h400; mem_wen = 1'b0; mem_req = 1'b1;
        run(4);
        check("rst_in_data", 32'(busy_ctl && !bus.bus_cs_en_ctl), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        check("rst_mid_outputs", any_out(), 32'd0);
        pend = 1'b0; a_cnt = 0;
        bus.bus_ready_top = 0; bus.bus_rvalid_top = 0; bus.bus_rdata_top = 0;
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        clear_logs();
        cfg_rvalid_wait = 1; cfg_rdata = 32'h55;
        if_addr = 32'h44; if_req = 1'b1;
        run(3);
        check("rst_after_gnt", 32'(n_if_gnt), 32'd1);
        check("rst_after_rv", 32'(n_if_rv), 32'd1);
        check("rst_after_data", last_if_rdata, 32'h55);

        check("invariants", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
